vec_alu_pipe: RTL and testbench
===============================

// Module: vec_alu_pipe
// PURPOSE
//  Pipelined, parametrised packed-SIMD vector ALU for the CGRA/RISC-V datapath.
//  Operates on LANES signed lanes of EW bits: lane add/sub with per-lane overflow,
//  dot product, and dot-product-accumulate into an internal accumulator.
//  Two-stage pipeline with valid/ready on both sides. Sits between the vector
//  register read port and the writeback arbiter.
// PARAMETERS
//  LANES  4   number of packed lanes (>=2)
//  EW     8   lane element width in bits (>=4)
//  DW     LANES*EW   operand/result width (derived, not overridden)
// PORTS
//  clk_i        in   1      clock, all state on rising edge
//  rst_n_i      in   1      asynchronous active-low reset
//  in_valid_i   in   1      operand beat valid
//  in_ready_o   out  1      block can accept a beat this cycle
//  op_i         in   3      opcode (see BEHAVIOUR), sampled with the beat
//  acc_clr_i    in   1      clear accumulator, sampled with the beat
//  v1_i         in   DW     operand A, lane k = bits [k*EW +: EW]
//  v2_i         in   DW     operand B
//  out_valid_o  out  1      result valid
//  out_ready_i  in   1      consumer accepts result
//  v_o          out  DW     result vector/scalar
//  over_o       out  LANES  per-lane signed overflow for the result beat
// BEHAVIOUR
//  Opcodes: VSUM=3'b010 lane a+b; VSUB=3'b110 lane a-b; VDP=3'b001 sum(a_k*b_k);
//   VDPA=3'b011 acc+=sum(a_k*b_k); any other code: v_o=v1_i, over_o=0.
//  Reset: s1_valid, out_valid_o, v_o, over_o and accumulator all 0.
//   Reset mid-operation discards in-flight beats; no partial output is produced.
//  Handshake: beat accepted when in_valid_i && in_ready_o; result retired when
//   out_valid_o && out_ready_i. adv2 = !out_valid_o || out_ready_i.
//   in_ready_o = !s1_valid || adv2 (combinational, no dependency on in_valid_i).
//   Latency 2 cycles from acceptance to out_valid_o; throughput 1 beat/cycle.
//   While out_valid_o && !out_ready_i: v_o and over_o hold stable; S1 holds one
//   beat; in_ready_o is 0. No beats are dropped or reordered.
//  S1 registers: lane sums/differences (EW+1 bits) or signed products (2*EW bits),
//   plus op and clr. S2 (load on adv2 && s1_valid): lane truncation/overflow, or
//   signed reduction of the products to 2*EW+clog2(LANES) bits, sign-extended to DW.
//  Overflow: over_o[k]=1 iff the true signed lane result is outside the EW-bit
//   range (true two's-complement overflow). over_o=0 for VDP/VDPA/default.
//  Accumulator: DW bits, wraps modulo 2^DW. It updates only when the beat loads S2.
//   If clr=1, the accumulator is zeroed first. VDPA with clr gives acc=dot.
//   Non-VDPA with clr gives acc=0, and v_o is the op's normal result.
//   VDPA: v_o = new accumulator value. Back-to-back VDPA beats use the
//   just-updated value, with no bubble.
// CONFIGURATION
//  VEC_ALU_SATURATE_EN defined: VSUM/VSUB lanes clamp on overflow to
//   2^(EW-1)-1 (positive) or -2^(EW-1) (negative); over_o still flags the lane.
//   Undefined: lanes wrap modulo 2^EW. VDP/VDPA are unaffected in both cases.
// STRUCTURE
//  vec_alu_pkg: opcode localparams (VSUM, VSUB, VDP, VDPA), the clog2 helper
//   function, and the derived reduction width.
//  Sub-module vec_alu_lane (one per lane via generate): registered add/sub/mul
//   for a single lane. Reduction, accumulator and handshake live in the top.
// TESTING (LANES=4, EW=8)
//  VSUM v1=0x0102037F v2=0x01010101 -> v_o=0x02030480 over=0001;
//   SATURATE_EN: v_o=0x0203047F.
//  VSUB v1=0x00000080 v2=0x00000001 -> v_o=0x0000007F over=0001;
//   SATURATE_EN: v_o=0x00000080.
//  VDP v1=0x01020304 v2=0x01010101 -> 0x0000000A; v1=0xFFFFFFFF -> 0xFFFFFFFC, over=0.
//  VDPA(clr=1), VDPA, VDPA(clr=1) back-to-back, each dot=10 -> v_o 0x0A, 0x14, 0x0A.
//  Hold out_ready_i=0 and offer 3 beats -> 2 accepted, in_ready_o=0 and v_o stable;
//   release -> 3 results in order, no loss.
//  Pulse rst_n_i low with both stages full -> out_valid_o=0 at once, no stale output.
//   Next VDPA (clr=0, dot=10) -> 0x0A.

Source files
------------

// File: rtl/vec_alu_pkg.sv
// Shared definitions for the packed-SIMD vector ALU: opcodes, lane modes,
// and the helpers that size the dot-product reduction.
package vec_alu_pkg;

    localparam logic [2:0] VSUM = 3'b010;
    localparam logic [2:0] VSUB = 3'b110;
    localparam logic [2:0] VDP  = 3'b001;
    localparam logic [2:0] VDPA = 3'b011;

    typedef enum logic [1:0] {
        LANE_ADD,
        LANE_SUB,
        LANE_PASS
    } lane_mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Width that holds the sum of all signed lane products without loss.
    function automatic int red_width(input int lanes, input int ew);
        return 2 * ew + clog2(lanes);
    endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// One SIMD lane of the first pipeline stage: registered sign-extended
// add/sub/pass result and the full-width signed product of the operands.
module vec_alu_lane
    import vec_alu_pkg::*;
#(
    parameter int EW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  lane_mode_e      mode,
    input  logic [EW-1:0]   a,
    input  logic [EW-1:0]   b,
    output logic [EW:0]     sum,
    output logic [2*EW-1:0] prod
);

    logic signed [EW:0]     a_ext;
    logic signed [EW:0]     b_ext;
    logic signed [2*EW-1:0] a_wide;
    logic signed [2*EW-1:0] b_wide;

    assign a_ext  = {a[EW-1], a};
    assign b_ext  = {b[EW-1], b};
    assign a_wide = {{EW{a[EW-1]}}, a};
    assign b_wide = {{EW{b[EW-1]}}, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            prod <= '0;
        end else if (en) begin
            case (mode)
                LANE_ADD: sum <= a_ext + b_ext;
                LANE_SUB: sum <= a_ext - b_ext;
                default:  sum <= a_ext;
            endcase
            prod <= a_wide * b_wide;
        end
    end

endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage packed-SIMD vector ALU with valid/ready on both sides.
// Define VEC_ALU_SATURATE_EN to clamp overflowing VSUM/VSUB lanes instead of wrapping.
module vec_alu_pipe
    import vec_alu_pkg::*;
#(
    parameter  int LANES = 4,
    parameter  int EW    = 8,
    localparam int DW    = LANES * EW
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic             acc_clr_i,
    input  logic [DW-1:0]    v1_i,
    input  logic [DW-1:0]    v2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    v_o,
    output logic [LANES-1:0] over_o
);

    localparam int RW = red_width(LANES, EW);

    logic                 s1_valid;
    logic [2:0]           s1_op;
    logic                 s1_clr;
    logic                 adv2;
    logic                 accept;
    lane_mode_e           lane_mode;
    logic [EW:0]          lane_sum  [LANES];
    logic [2*EW-1:0]      lane_prod [LANES];
    logic signed [RW-1:0] dot;
    logic [DW-1:0]        dot_ext;
    logic [DW-1:0]        acc;
    logic [DW-1:0]        acc_base;
    logic [DW-1:0]        acc_next;
    logic [DW-1:0]        res;
    logic [LANES-1:0]     ovf;

    assign adv2       = !out_valid_o || out_ready_i;
    assign in_ready_o = !s1_valid || adv2;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        lane_mode = LANE_PASS;
        if (op_i == VSUM) begin
            lane_mode = LANE_ADD;
        end else if (op_i == VSUB) begin
            lane_mode = LANE_SUB;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        vec_alu_lane #(.EW(EW)) u_lane (
            .clk   (clk_i),
            .rst_n (rst_n_i),
            .en    (accept),
            .mode  (lane_mode),
            .a     (v1_i[k*EW +: EW]),
            .b     (v2_i[k*EW +: EW]),
            .sum   (lane_sum[k]),
            .prod  (lane_prod[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_clr   <= 1'b0;
        end else if (in_ready_o) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_op  <= op_i;
                s1_clr <= acc_clr_i;
            end
        end
    end

    // The accumulator is read here, so a VDPA right behind another sees its update.
    always_comb begin
        dot = '0;
        for (int k = 0; k < LANES; k++) begin
            dot = dot + RW'(signed'(lane_prod[k]));
        end
        dot_ext  = DW'(dot);
        acc_base = s1_clr ? '0 : acc;
        acc_next = acc_base;
        res      = '0;
        ovf      = '0;
        case (s1_op)
            VSUM, VSUB: begin
                for (int k = 0; k < LANES; k++) begin
                    ovf[k] = lane_sum[k][EW] ^ lane_sum[k][EW-1];
                    res[k*EW +: EW] = lane_sum[k][EW-1:0];
`ifdef VEC_ALU_SATURATE_EN
                    if (ovf[k]) begin
                        res[k*EW +: EW] = lane_sum[k][EW] ? {1'b1, {(EW-1){1'b0}}}
                                                          : {1'b0, {(EW-1){1'b1}}};
                    end
`endif
                end
            end
            VDP: res = dot_ext;
            VDPA: begin
                acc_next = acc_base + dot_ext;
                res      = acc_next;
            end
            default: begin
                for (int k = 0; k < LANES; k++) begin
                    res[k*EW +: EW] = lane_sum[k][EW-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            v_o         <= '0;
            over_o      <= '0;
            acc         <= '0;
        end else begin
            if (adv2) begin
                out_valid_o <= s1_valid;
            end
            if (adv2 && s1_valid) begin
                v_o    <= res;
                over_o <= ovf;
                acc    <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Self-checking bench for vec_alu_pipe (LANES=4, EW=8): directed corner beats
// plus randomized traffic and back-pressure against a behavioural model.
module tb_vec_alu_pipe;

    localparam int LANES = 4;
    localparam int EW    = 8;
    localparam int DW    = LANES * EW;
    localparam int RBW   = DW + LANES;
    localparam logic [2:0] OP_SUM = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_DP  = 3'b001;
    localparam logic [2:0] OP_DPA = 3'b011;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc_clr;
    logic [DW-1:0]    v1;
    logic [DW-1:0]    v2;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    v;
    logic [LANES-1:0] over;

    int               vectors;
    int               miscompares;
    bit               rand_bp;
    logic [DW-1:0]    model_acc;
    logic [RBW-1:0]   exp_q [$];
    logic [RBW-1:0]   got   [$];

    vec_alu_pipe #(.LANES(LANES), .EW(EW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .acc_clr_i   (acc_clr),
        .v1_i        (v1),
        .v2_i        (v2),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .v_o         (v),
        .over_o      (over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Captures each result beat that will retire on the coming rising edge.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) got.push_back({v, over});
    end

    // Behavioural model working on integer lane values; updates model_acc in beat order.
    function automatic logic [RBW-1:0] ref_model(input logic [2:0] o, input logic clr,
                                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0]    res;
        logic [LANES-1:0] ov;
        longint           d;
        int               x, y, r;
        int               hi, lo;
        hi  = (1 << (EW - 1)) - 1;
        lo  = -(1 << (EW - 1));
        res = '0;
        ov  = '0;
        d   = 0;
        for (int k = 0; k < LANES; k++) begin
            x = int'($signed(a[k*EW +: EW]));
            y = int'($signed(b[k*EW +: EW]));
            d += longint'(x * y);
        end
        if (clr) model_acc = '0;
        case (o)
            OP_SUM, OP_SUB: begin
                for (int k = 0; k < LANES; k++) begin
                    x = int'($signed(a[k*EW +: EW]));
                    y = int'($signed(b[k*EW +: EW]));
                    r = (o == OP_SUM) ? x + y : x - y;
                    if (r > hi || r < lo) begin
                        ov[k] = 1'b1;
`ifdef VEC_ALU_SATURATE_EN
                        r = (r > hi) ? hi : lo;
`endif
                    end
                    res[k*EW +: EW] = r[EW-1:0];
                end
            end
            OP_DP:  res = d[DW-1:0];
            OP_DPA: begin
                model_acc = model_acc + d[DW-1:0];
                res       = model_acc;
            end
            default: res = a;
        endcase
        return {res, ov};
    endfunction

    task automatic offer(input logic [2:0] o, input logic clr, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, output bit took);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        acc_clr  = clr;
        v1       = a;
        v2       = b;
        #1;
        took = in_ready;
        @(posedge clk);
        if (took) exp_q.push_back(ref_model(o, clr, a, b));
    endtask

    task automatic send(input logic [2:0] o, input logic clr, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
        bit took;
        for (int i = 0; i < 100; i++) begin
            offer(o, clr, a, b, took);
            if (took) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL send_timeout: in_ready stayed 0, want 1");
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        for (int i = 0; i < 400; i++) begin
            if (got.size() >= exp_q.size()) break;
            @(negedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        if (v !== '0) begin miscompares++; $display("[TB] FAIL reset_v: got %h want 0", v); end
        if (over !== '0) begin miscompares++; $display("[TB] FAIL reset_over: got %b want 0", over); end
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        model_acc = '0;
    endtask

    task automatic test_vsum();
        logic [RBW-1:0] g, e;
        send(OP_SUM, 1'b0, 32'h0102037F, 32'h01010101);
        for (int i = 0; i < 10; i++) send(OP_SUM, 1'b0, $urandom, $urandom);
        drain();
        vectors++;
        if (got.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL vsum_count: got %0d want %0d", got.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front();
            g = got.pop_front();
            vectors++;
            if (g !== e) begin miscompares++; $display("[TB] FAIL vsum: got v=%h over=%b want v=%h over=%b", g[RBW-1:LANES], g[LANES-1:0], e[RBW-1:LANES], e[LANES-1:0]); end
        end
        exp_q.delete(); got.delete();
    endtask

    task automatic test_vsub();
        logic [RBW-1:0] g, e;
        send(OP_SUB, 1'b0, 32'h00000080, 32'h00000001);
        for (int i = 0; i < 10; i++) send(OP_SUB, 1'b0, $urandom, $urandom);
        drain();
        vectors++;
        if (got.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL vsub_count: got %0d want %0d", got.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front();
            g = got.pop_front();
            vectors++;
            if (g !== e) begin miscompares++; $display("[TB] FAIL vsub: got v=%h over=%b want v=%h over=%b", g[RBW-1:LANES], g[LANES-1:0], e[RBW-1:LANES], e[LANES-1:0]); end
        end
        exp_q.delete(); got.delete();
    endtask

    task automatic test_vdp();
        logic [RBW-1:0] g, e;
        send(OP_DP, 1'b0, 32'h01020304, 32'h01010101);
        send(OP_DP, 1'b0, 32'hFFFFFFFF, 32'h01010101);
        send(OP_DP, 1'b0, 32'h80808080, 32'h80808080);
        for (int i = 0; i < 8; i++) send(OP_DP, 1'($urandom_range(0, 1)), $urandom, $urandom);
        drain();
        vectors++;
        if (got.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL vdp_count: got %0d want %0d", got.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front();
            g = got.pop_front();
            vectors++;
            if (g !== e) begin miscompares++; $display("[TB] FAIL vdp: got v=%h over=%b want v=%h over=%b", g[RBW-1:LANES], g[LANES-1:0], e[RBW-1:LANES], e[LANES-1:0]); end
        end
        exp_q.delete(); got.delete();
    endtask

    task automatic test_back_to_back();
        logic [RBW-1:0] g, e;
        send(OP_DPA, 1'b1, 32'h01020304, 32'h01010101);
        send(OP_DPA, 1'b0, 32'h01020304, 32'h01010101);
        send(OP_DPA, 1'b1, 32'h01020304, 32'h01010101);
        send(OP_DPA, 1'b0, $urandom, $urandom);
        send(OP_SUM, 1'b1, $urandom, $urandom);
        send(OP_DPA, 1'b0, 32'h01020304, 32'h01010101);
        drain();
        vectors++;
        if (got.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL vdpa_count: got %0d want %0d", got.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front();
            g = got.pop_front();
            vectors++;
            if (g !== e) begin miscompares++; $display("[TB] FAIL vdpa: got v=%h over=%b want v=%h over=%b", g[RBW-1:LANES], g[LANES-1:0], e[RBW-1:LANES], e[LANES-1:0]); end
        end
        exp_q.delete(); got.delete();
    endtask

    task automatic test_backpressure();
        logic [RBW-1:0] g, e, snap;
        bit took;
        @(negedge clk);
        out_ready = 1'b0;
        offer(OP_SUM, 1'b0, 32'h0102037F, 32'h01010101, took);
        vectors++;
        if (took !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_accept_a: got %b want 1", took); end
        offer(OP_SUB, 1'b0, 32'h00000080, 32'h00000001, took);
        vectors++;
        if (took !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_accept_b: got %b want 1", took); end
        #1 snap = {v, over};
        vectors++;
        if (exp_q.size() == 0 || snap !== exp_q[0]) begin miscompares++; $display("[TB] FAIL bp_head: got %h want first beat result", snap); end
        for (int i = 0; i < 3; i++) begin
            offer(OP_DP, 1'b0, 32'h01020304, 32'h01010101, took);
            vectors += 2;
            if (took !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready: got %b want 0", took); end
            #1;
            if ({out_valid, v, over} !== {1'b1, snap}) begin miscompares++; $display("[TB] FAIL bp_hold: got valid=%b %h want valid=1 %h", out_valid, {v, over}, snap); end
        end
        out_ready = 1'b1;
        send(OP_DP, 1'b0, 32'h01020304, 32'h01010101);
        drain();
        vectors++;
        if (got.size() !== 3 || exp_q.size() !== 3) begin miscompares++; $display("[TB] FAIL bp_count: got %0d want 3", got.size()); end
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front();
            g = got.pop_front();
            vectors++;
            if (g !== e) begin miscompares++; $display("[TB] FAIL bp_order: got v=%h over=%b want v=%h over=%b", g[RBW-1:LANES], g[LANES-1:0], e[RBW-1:LANES], e[LANES-1:0]); end
        end
        exp_q.delete(); got.delete();
    endtask

    task automatic test_random();
        logic [RBW-1:0] g, e;
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0), $urandom, $urandom);
        end
        drain();
        rand_bp = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        vectors++;
        if (got.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL random_count: got %0d want %0d", got.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front();
            g = got.pop_front();
            vectors++;
            if (g !== e) begin miscompares++; $display("[TB] FAIL random: got v=%h over=%b want v=%h over=%b", g[RBW-1:LANES], g[LANES-1:0], e[RBW-1:LANES], e[LANES-1:0]); end
        end
        exp_q.delete(); got.delete();
    endtask

    task automatic test_reset_midflight();
        logic [RBW-1:0] g, e;
        bit took;
        send(OP_DPA, 1'b1, 32'h05050505, 32'h01010101);
        drain();
        exp_q.delete(); got.delete();
        @(negedge clk);
        out_ready = 1'b0;
        offer(OP_DPA, 1'b0, 32'h01020304, 32'h01010101, took);
        offer(OP_SUM, 1'b0, 32'h11111111, 32'h22222222, took);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, v, over} !== '0) begin miscompares++; $display("[TB] FAIL midreset_clear: got valid=%b v=%h over=%b want all 0", out_valid, v, over); end
        #1 rst_n = 1'b1;
        exp_q.delete(); got.delete();
        model_acc = '0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        vectors++;
        if (got.size() !== 0 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_stale: got %0d results valid=%b want 0", got.size(), out_valid); end
        send(OP_DPA, 1'b0, 32'h01020304, 32'h01010101);
        drain();
        vectors++;
        if (got.size() !== 1) begin miscompares++; $display("[TB] FAIL midreset_count: got %0d want 1", got.size()); end
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front();
            g = got.pop_front();
            vectors++;
            if (g !== e) begin miscompares++; $display("[TB] FAIL midreset_vdpa: got v=%h want v=%h", g[RBW-1:LANES], e[RBW-1:LANES]); end
        end
        exp_q.delete(); got.delete();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rand_bp     = 1'b0;
        model_acc   = '0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        op          = '0;
        acc_clr     = 1'b0;
        v1          = '0;
        v2          = '0;
        out_ready   = 1'b1;
        test_reset();
        test_vsum();
        test_vsub();
        test_vdp();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
